// File: rtl/multi_runtime_cnt.sv
// multi_runtime_cnt: NUM_CH independent run-time counters.
// Each channel latches its terminal count on start, counts 0..work_time while
// busy, then pulses done for one cycle. A channel can be aborted at any time.
// Optional busy-cycle statistics are enabled by defining RUNTIME_CNT_STAT_EN;
// without it busy_cycles is tied to zero and stat_clr is unused.
module multi_runtime_cnt #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int STAT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH-1:0]         abort,
    input  logic [NUM_CH*CNT_W-1:0]   work_time,
    input  logic                      stat_clr,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH*CNT_W-1:0]   ctr_cnt,
    output logic                      all_idle,
    output logic [STAT_W-1:0]         busy_cycles
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Next-state busy bits of every channel, used to keep all_idle aligned with busy
    logic [NUM_CH-1:0] w_busy_next;
    logic              r_all_idle;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_wt;
            logic             r_done;
            logic             w_start;
            logic             w_term;

            assign w_start = enable[gi] & ~abort[gi];
            assign w_term  = (r_cnt == r_wt);

            // Abort wins over completion; enable only matters while idle
            assign w_busy_next[gi] = ~rst & ((r_state == S_RUN) ? ~(abort[gi] | w_term)
                                                                : w_start);

            // Per-channel IDLE/RUN state machine with registered count and done pulse
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_wt    <= '0;
                    r_done  <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_cnt  <= '0;
                            r_done <= 1'b0;
                            if (w_start) begin
                                r_state <= S_RUN;
                                r_wt    <= work_time[gi*CNT_W +: CNT_W];
                            end
                        end
                        S_RUN: begin
                            if (abort[gi]) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                                r_done  <= 1'b0;
                            end else if (w_term) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_done  <= 1'b0;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b0;
                        end
                    endcase
                end
            end

            assign busy[gi]                      = (r_state == S_RUN);
            assign done[gi]                      = r_done;
            assign ctr_cnt[gi*CNT_W +: CNT_W]    = r_cnt;
        end
    endgenerate

    // all_idle tracks the NOR of the next busy bits so it changes with busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_all_idle <= 1'b1;
        end else begin
            r_all_idle <= ~|w_busy_next;
        end
    end

    assign all_idle = r_all_idle;

`ifdef RUNTIME_CNT_STAT_EN
    localparam int POP_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((STAT_W > POP_W) ? STAT_W : POP_W) + 1;

    logic [STAT_W-1:0] r_busy_cycles;
    logic [POP_W-1:0]  w_popcnt;
    logic [SUM_W-1:0]  w_sum;
    logic [SUM_W-1:0]  w_max;

    // Number of channels busy this cycle
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_popcnt = w_popcnt + POP_W'(busy[i]);
        end
    end

    assign w_sum = SUM_W'(r_busy_cycles) + SUM_W'(w_popcnt);
    assign w_max = SUM_W'({STAT_W{1'b1}});

    // Saturating busy-cycle accumulator; a clear discards this cycle's increment
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_busy_cycles <= '0;
        end else if (w_sum > w_max) begin
            r_busy_cycles <= '1;
        end else begin
            r_busy_cycles <= w_sum[STAT_W-1:0];
        end
    end

    assign busy_cycles = r_busy_cycles;
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = stat_clr;
    assign busy_cycles       = '0;
`endif

endmodule

// File: tb/tb_multi_runtime_cnt.sv
// Scoreboard bench for multi_runtime_cnt: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them against the DUT.
// A second instance with STAT_W=4 shares the inputs to exercise saturation.
module tb_multi_runtime_cnt;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    localparam int K_BUSY  = 0;
    localparam int K_DONE  = 1;
    localparam int K_CNT   = 2;
    localparam int K_IDLE  = 3;
    localparam int K_STAT  = 4;
    localparam int K_STAT4 = 5;

`ifdef RUNTIME_CNT_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH*CNT_W-1:0] work_time;
    logic                    stat_clr;
    logic [NUM_CH-1:0]       busy, done, busy4, done4;
    logic [NUM_CH*CNT_W-1:0] ctr_cnt, ctr_cnt4;
    logic                    all_idle, all_idle4;
    logic [31:0]             busy_cycles;
    logic [3:0]              busy_cycles4;

    multi_runtime_cnt #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STAT_W(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort),
        .work_time(work_time), .stat_clr(stat_clr), .busy(busy), .done(done),
        .ctr_cnt(ctr_cnt), .all_idle(all_idle), .busy_cycles(busy_cycles)
    );

    multi_runtime_cnt #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STAT_W(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort),
        .work_time(work_time), .stat_clr(stat_clr), .busy(busy4), .done(done4),
        .ctr_cnt(ctr_cnt4), .all_idle(all_idle4), .busy_cycles(busy_cycles4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int ch;
        int val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic string kname(int k);
        case (k)
            K_BUSY:  return "busy";
            K_DONE:  return "done";
            K_CNT:   return "ctr_cnt";
            K_IDLE:  return "all_idle";
            K_STAT:  return "busy_cycles";
            K_STAT4: return "busy_cycles_w4";
            default: return "unknown";
        endcase
    endfunction

    // Insert keeping the queue ordered by cycle
    function automatic void exp_push(int c, int k, int ch, int v);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        e.val  = ((k == K_STAT) || (k == K_STAT4)) ? (STAT_ON ? v : 0) : v;
        idx    = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
    endfunction

    // Full run of work time wt starting (busy first high) at cycle st
    function automatic void push_run(int ch, int st, int wt);
        for (int k = 0; k <= wt; k++) begin
            exp_push(st + k, K_BUSY, ch, 1);
            exp_push(st + k, K_CNT,  ch, k);
            exp_push(st + k, K_DONE, ch, 0);
        end
        exp_push(st + wt + 1, K_BUSY, ch, 0);
        exp_push(st + wt + 1, K_CNT,  ch, 0);
        exp_push(st + wt + 1, K_DONE, ch, 1);
        exp_push(st + wt + 2, K_DONE, ch, 0);
    endfunction

    // Monitor: pop every expectation due this cycle and compare
    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            checks++;
            if (m_e.cyc < cyc) begin
                errors++;
                $display("FAIL stale_%s cyc=%0d ch=%0d: not checked at cycle %0d", kname(m_e.kind), cyc, m_e.ch, m_e.cyc);
            end else begin
                case (m_e.kind)
                    K_BUSY:  m_act = 32'(busy[m_e.ch]);
                    K_DONE:  m_act = 32'(done[m_e.ch]);
                    K_CNT:   m_act = 32'(ctr_cnt[m_e.ch*CNT_W +: CNT_W]);
                    K_IDLE:  m_act = 32'(all_idle);
                    K_STAT:  m_act = busy_cycles;
                    default: m_act = 32'(busy_cycles4);
                endcase
                if (m_act !== 32'(m_e.val)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d ch=%0d actual=%0d expected=%0d", kname(m_e.kind), cyc, m_e.ch, m_act, m_e.val);
                end else begin
                    $display("ok   %s cyc=%0d ch=%0d value=%0d", kname(m_e.kind), cyc, m_e.ch, m_act);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int t0;

    initial begin
        rst       = 1'b1;
        enable    = '0;
        abort     = '0;
        work_time = '0;
        stat_clr  = 1'b0;

        // Reset state
        for (int c = 1; c <= 3; c++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                exp_push(c, K_BUSY, ch, 0);
                exp_push(c, K_DONE, ch, 0);
                exp_push(c, K_CNT,  ch, 0);
            end
            exp_push(c, K_IDLE, 0, 1);
            exp_push(c, K_STAT, 0, 0);
        end
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single run, ch0 work_time=5
        t0 = cyc;
        work_time[0*CNT_W +: CNT_W] = 16'd5;
        enable   = 4'b0001;
        stat_clr = 1'b1;
        push_run(0, t0 + 1, 5);
        exp_push(t0 + 1, K_IDLE, 0, 0);
        exp_push(t0 + 1, K_STAT, 0, 0);
        exp_push(t0 + 7, K_IDLE, 0, 1);
        exp_push(t0 + 7, K_STAT, 0, 6);
        tick();
        enable   = '0;
        stat_clr = 1'b0;
        tick(9);

        // Zero work time, ch1
        t0 = cyc;
        work_time[1*CNT_W +: CNT_W] = 16'd0;
        enable = 4'b0010;
        push_run(1, t0 + 1, 0);
        tick();
        enable = '0;
        tick(3);

        // Held enable, ch2 work_time=3: restart every 5 cycles
        t0 = cyc;
        work_time[2*CNT_W +: CNT_W] = 16'd3;
        enable = 4'b0100;
        for (int r = 0; r < 3; r++) push_run(2, t0 + 1 + 5*r, 3);
        tick(15);
        enable = '0;
        tick(3);

        // Live work_time change does not shorten the run, ch3
        t0 = cyc;
        work_time[3*CNT_W +: CNT_W] = 16'd10;
        enable = 4'b1000;
        push_run(3, t0 + 1, 10);
        tick();
        enable = '0;
        work_time[3*CNT_W +: CNT_W] = 16'd2;
        tick(13);

        // Abort at ctr_cnt=4
        t0 = cyc;
        work_time[3*CNT_W +: CNT_W] = 16'd10;
        enable = 4'b1000;
        for (int k = 0; k <= 4; k++) begin
            exp_push(t0 + 1 + k, K_BUSY, 3, 1);
            exp_push(t0 + 1 + k, K_CNT,  3, k);
        end
        exp_push(t0 + 6, K_BUSY, 3, 0);
        exp_push(t0 + 6, K_CNT,  3, 0);
        exp_push(t0 + 6, K_DONE, 3, 0);
        exp_push(t0 + 7, K_DONE, 3, 0);
        tick();
        enable = '0;
        tick(4);
        abort = 4'b1000;
        tick();
        abort = '0;
        tick(3);

        // Abort on the terminal cycle, then abort blocking an idle enable
        t0 = cyc;
        work_time[3*CNT_W +: CNT_W] = 16'd2;
        enable = 4'b1000;
        for (int k = 0; k <= 2; k++) begin
            exp_push(t0 + 1 + k, K_BUSY, 3, 1);
            exp_push(t0 + 1 + k, K_CNT,  3, k);
        end
        exp_push(t0 + 4, K_BUSY, 3, 0);
        exp_push(t0 + 4, K_DONE, 3, 0);
        exp_push(t0 + 5, K_BUSY, 3, 0);
        exp_push(t0 + 5, K_DONE, 3, 0);
        exp_push(t0 + 6, K_BUSY, 3, 0);
        tick();
        enable = '0;
        tick(2);
        abort = 4'b1000;
        tick();
        enable = 4'b1000;
        tick();
        enable = '0;
        abort  = '0;
        tick(3);

        // All four channels concurrently, work_time=7, with statistics
        t0 = cyc;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            work_time[ch*CNT_W +: CNT_W] = 16'd7;
            push_run(ch, t0 + 1, 7);
        end
        enable   = 4'b1111;
        stat_clr = 1'b1;
        for (int c = 1; c <= 8; c++) exp_push(t0 + c, K_IDLE, 0, 0);
        exp_push(t0 + 9, K_IDLE,  0, 1);
        exp_push(t0 + 1, K_STAT,  0, 0);
        exp_push(t0 + 5, K_STAT,  0, 16);
        exp_push(t0 + 9, K_STAT,  0, 32);
        exp_push(t0 + 1, K_STAT4, 0, 0);
        exp_push(t0 + 4, K_STAT4, 0, 12);
        exp_push(t0 + 5, K_STAT4, 0, 15);
        exp_push(t0 + 9, K_STAT4, 0, 15);
        tick();
        enable   = '0;
        stat_clr = 1'b0;
        tick(10);

        // Reset mid-run, then immediate restart after release
        t0 = cyc;
        enable = 4'b1111;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int k = 0; k <= 2; k++) begin
                exp_push(t0 + 1 + k, K_BUSY, ch, 1);
                exp_push(t0 + 1 + k, K_CNT,  ch, k);
            end
            exp_push(t0 + 4, K_BUSY, ch, 0);
            exp_push(t0 + 4, K_DONE, ch, 0);
            exp_push(t0 + 4, K_CNT,  ch, 0);
            push_run(ch, t0 + 5, 7);
        end
        exp_push(t0 + 4, K_IDLE,  0, 1);
        exp_push(t0 + 4, K_STAT,  0, 0);
        exp_push(t0 + 4, K_STAT4, 0, 0);
        exp_push(t0 + 5, K_IDLE,  0, 0);
        exp_push(t0 + 5, K_STAT,  0, 0);
        exp_push(t0 + 6, K_STAT,  0, 4);
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        enable = '0;
        tick(10);

        tick(2);
        while (q.size() > 0) begin
            m_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL unchecked_%s ch=%0d: expectation for cycle %0d never reached", kname(m_e.kind), m_e.ch, m_e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
